// File: rtl/trig_info_fifo.sv
// trig_info_fifo: first-word-fall-through queue of trigger records.
// Each trig_i latches the L4 pattern, delay and info word and tags it with a
// 16-bit event number. Readout drains the queue with a valid/ready handshake.
// busy_o feeds the trigger core's disable input before the queue fills up.
// Optional feature: define TRIG_INFO_TIMESTAMP_EN to add a PPS-aligned
// 32-bit fclk timestamp to every entry. Without it, rd_tstamp_o is 0 and
// pps_flag_fclk_i is ignored.
module trig_info_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int HEADROOM   = 2
) (
  input  logic                  fclk_i,
  input  logic                  rst_n_i,
  input  logic                  trig_i,
  input  logic [3:0]            trig_l4_i,
  input  logic [8:0]            trig_delay_i,
  input  logic [31:0]           trig_info_i,
  input  logic                  pps_flag_fclk_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [3:0]            rd_l4_o,
  output logic [8:0]            rd_delay_o,
  output logic [31:0]           rd_info_o,
  output logic [15:0]           rd_evnum_o,
  output logic [31:0]           rd_tstamp_o,
  output logic                  busy_o,
  output logic [15:0]           drop_count_o,
  output logic [DEPTH_LOG2:0]   occupancy_o
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] BUSY_LVL = (DEPTH_LOG2+1)'(DEPTH - HEADROOM);
  localparam logic [DEPTH_LOG2:0] OCC_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef struct packed {
    logic [3:0]  l4;
    logic [8:0]  delay;
    logic [31:0] info;
    logic [15:0] evnum;
`ifdef TRIG_INFO_TIMESTAMP_EN
    logic [31:0] tstamp;
`endif
  } entry_t;

  entry_t                  r_mem [DEPTH];
  entry_t                  r_head;
  entry_t                  w_new;
  entry_t                  w_head_nxt;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2-1:0]   w_rd_ptr_nxt;
  logic [DEPTH_LOG2:0]     r_occ;
  logic [DEPTH_LOG2:0]     w_occ_nxt;
  logic                    r_valid;
  logic                    r_busy;
  logic [15:0]             r_drop;
  logic [15:0]             r_evnum;
  logic                    w_full;
  logic                    w_wr_en;
  logic                    w_pop;

  // Fullness comes from the registered count, so a same-cycle pop never rescues a write.
  assign w_full       = (r_occ == FULL_LVL);
  assign w_wr_en      = trig_i && !w_full;
  assign w_pop        = r_valid && rd_ready_i;
  assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

`ifdef TRIG_INFO_TIMESTAMP_EN
  logic [31:0] r_tstamp;

  // Free-running fclk counter, re-zeroed the cycle after each PPS flag.
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    if (!rst_n_i)             r_tstamp <= '0;
    else if (pps_flag_fclk_i) r_tstamp <= '0;
    else                      r_tstamp <= r_tstamp + 32'd1;
  end
`else
  logic w_unused_pps;
  assign w_unused_pps = pps_flag_fclk_i;
`endif

  // Assemble the record for the trigger in this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_new       = '0;
    w_new.l4    = trig_l4_i;
    w_new.delay = trig_delay_i;
    w_new.info  = trig_info_i;
    w_new.evnum = r_evnum;
`ifdef TRIG_INFO_TIMESTAMP_EN
    w_new.tstamp = r_tstamp;
`endif
  end

  // Next occupancy and next head; a write landing on the new head slot is forwarded.
  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_wr_en, w_pop})
      2'b10:   w_occ_nxt = r_occ + OCC_ONE;
      2'b01:   w_occ_nxt = r_occ - OCC_ONE;
      default: w_occ_nxt = r_occ;
    endcase
    if (w_wr_en && (w_rd_ptr_nxt == r_wr_ptr)) w_head_nxt = w_new;
    else                                        w_head_nxt = r_mem[w_rd_ptr_nxt];
  end

  // Storage array write port.
  // NOTE: the array is deliberately not reset; occupancy and pointers define which slots are live.
  always_ff @(posedge fclk_i) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_new;
  end

  // Pointers, occupancy, prefetch head register and busy flag.
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_occ    <= w_occ_nxt;
      r_valid  <= (w_occ_nxt != '0);
      r_busy   <= (w_occ_nxt >= BUSY_LVL);
      r_head   <= w_head_nxt;
    end
  end

  // Event numbering counts every trigger, dropped or not; drop count saturates.
  always_ff @(posedge fclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_evnum <= '0;
      r_drop  <= '0;
    end else begin
      if (trig_i) r_evnum <= r_evnum + 16'd1;
      if (trig_i && w_full && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

  assign rd_valid_o   = r_valid;
  assign rd_l4_o      = r_head.l4;
  assign rd_delay_o   = r_head.delay;
  assign rd_info_o    = r_head.info;
  assign rd_evnum_o   = r_head.evnum;
`ifdef TRIG_INFO_TIMESTAMP_EN
  assign rd_tstamp_o  = r_head.tstamp;
`else
  assign rd_tstamp_o  = 32'd0;
`endif
  assign busy_o       = r_busy;
  assign drop_count_o = r_drop;
  assign occupancy_o  = r_occ;

endmodule

// File: tb/tb_trig_info_fifo.sv
// Scoreboard bench for trig_info_fifo (DEPTH_LOG2=4, HEADROOM=2).
// Stimulus pushes expected records; a negedge monitor pops on each handshake.
module tb_trig_info_fifo;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [3:0]  l4 = '0;
  logic [8:0]  dly = '0;
  logic [31:0] info = '0;
  logic        pps = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [3:0]  rd_l4;
  logic [8:0]  rd_delay;
  logic [31:0] rd_info;
  logic [15:0] rd_evnum;
  logic [31:0] rd_tstamp;
  logic        busy;
  logic [15:0] drop_count;
  logic [4:0]  occ;

  trig_info_fifo #(.DEPTH_LOG2(4), .HEADROOM(2)) dut (
    .fclk_i          (fclk),
    .rst_n_i         (rst_n),
    .trig_i          (trig),
    .trig_l4_i       (l4),
    .trig_delay_i    (dly),
    .trig_info_i     (info),
    .pps_flag_fclk_i (pps),
    .rd_valid_o      (rd_valid),
    .rd_ready_i      (rd_ready),
    .rd_l4_o         (rd_l4),
    .rd_delay_o      (rd_delay),
    .rd_info_o       (rd_info),
    .rd_evnum_o      (rd_evnum),
    .rd_tstamp_o     (rd_tstamp),
    .busy_o          (busy),
    .drop_count_o    (drop_count),
    .occupancy_o     (occ)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    logic [3:0]  l4;
    logic [8:0]  dly;
    logic [31:0] info;
    logic [15:0] ev;
    logic [31:0] ts;
    bit          chk_ts;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] ev_model = '0;
  int          cyc = 0;
  int          n_pop = 0;
  int          first_pop = -1;
  int          last_pop = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge fclk) cyc++;

  // Monitor: every handshake pops the oldest expected record.
  always @(negedge fclk) begin
    exp_t e;
    if (rst_n && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_pop: DUT presented evnum 0x%0h with nothing expected", rd_evnum);
      end else begin
        e = sb.pop_front();
        check("rd_l4", rd_l4, e.l4);
        check("rd_delay", rd_delay, e.dly);
        check("rd_info", rd_info, e.info);
        check("rd_evnum", rd_evnum, e.ev);
`ifdef TRIG_INFO_TIMESTAMP_EN
        if (e.chk_ts) check("rd_tstamp", rd_tstamp, e.ts);
`else
        check("rd_tstamp", rd_tstamp, 32'd0);
`endif
      end
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  // One-cycle trigger; the record is expected only when the FIFO should accept it.
  task automatic trig_pulse(input logic [3:0] a, input logic [8:0] b, input logic [31:0] c,
                            input bit acc, input bit chk_ts = 1'b0, input logic [31:0] ts = '0);
    exp_t e;
    l4 = a; dly = b; info = c; trig = 1'b1;
    e = '{a, b, c, ev_model, ts, chk_ts};
    if (acc) sb.push_back(e);
    ev_model++;
    @(posedge fclk);
    #1;
    trig = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drop"}, drop_count, 0);
    check({tag, "_occ"}, occ, 0);
    check({tag, "_l4"}, rd_l4, 0);
    check({tag, "_delay"}, rd_delay, 0);
    check({tag, "_info"}, rd_info, 0);
    check({tag, "_evnum"}, rd_evnum, 0);
    check({tag, "_tstamp"}, rd_tstamp, 0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    sb.delete();
    ev_model = '0;
    #1;
    check_reset_outputs(tag);
    @(negedge fclk);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic drain(input string tag, input int bound);
    int k;
    k = 0;
    rd_ready = 1'b1;
    while (rd_valid && k < bound) begin
      @(posedge fclk);
      #1;
      k++;
    end
    check({tag, "_drained"}, rd_valid, 0);
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    check_reset_outputs("rst");
    @(negedge fclk);
    rst_n = 1'b1;
    tick(1);

    // Single trigger, consumer ready
    rd_ready = 1'b1;
    trig_pulse(4'h5, 9'h1A3, 32'hDEADBEEF, 1);
    @(negedge fclk);
    check("single_valid_n1", rd_valid, 1);
    @(negedge fclk);
    check("single_valid_n2", rd_valid, 0);
    check("single_sb_empty", sb.size(), 0);
    rd_ready = 1'b0;
    tick(1);

    // Fill and overflow from a fresh reset
    apply_reset("rst2");
    for (int i = 1; i <= 18; i++) begin
      trig_pulse(4'(i), 9'(i * 3), 32'hA000_0000 + i, i <= 16);
      if (i == 13) check("busy_after_13", busy, 0);
      if (i == 14) check("busy_after_14", busy, 1);
    end
    check("ovf_occ", occ, 16);
    check("ovf_drop", drop_count, 2);
    check("ovf_busy", busy, 1);
    check("ovf_head_ev", rd_evnum, 0);
    drain("ovf", 40);
    check("ovf_occ_after", occ, 0);
    check("ovf_busy_after", busy, 0);
    check("ovf_drop_after", drop_count, 2);
    rd_ready = 1'b1;
    trig_pulse(4'hC, 9'h055, 32'h12345678, 1);   // expects evnum 18
    tick(2);
    rd_ready = 1'b0;

    // Simultaneous write and pop at occupancy 3
    for (int i = 0; i < 3; i++) trig_pulse(4'(i + 1), 9'(16 + i), 32'hB0 + i, 1);
    check("sim_occ_before", occ, 3);
    rd_ready = 1'b1;
    trig_pulse(4'h4, 9'h013, 32'hB3, 1);
    rd_ready = 1'b0;
    check("sim_occ_after", occ, 3);
    check("sim_head_ev", rd_evnum, 20);
    drain("sim", 10);

    // Write at full with a pop: write dropped, occupancy 15
    for (int i = 0; i < 16; i++) trig_pulse(4'(i), 9'(i), 32'hC000 + i, 1);
    check("full_occ", occ, 16);
    rd_ready = 1'b1;
    trig_pulse(4'hF, 9'h1FF, 32'hFFFF_FFFF, 0);
    rd_ready = 1'b0;
    check("full_pop_occ", occ, 15);
    check("full_pop_drop", drop_count, 3);
    check("full_pop_busy", busy, 1);
    drain("full", 30);

    // Back-to-back triggers with consumer always ready
    apply_reset("rst3");
    n_pop = 0;
    first_pop = -1;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) trig_pulse(4'(i), 9'(256 + i), 32'hD0 + i, 1);
    tick(2);
    check("b2b_pops", n_pop, 8);
    check("b2b_span", last_pop - first_pop, 7);
    check("b2b_drop", drop_count, 0);
    check("b2b_valid_end", rd_valid, 0);
    rd_ready = 1'b0;

    // Reset mid-operation
    for (int i = 0; i < 5; i++) trig_pulse(4'(i), 9'(i), 32'hE0 + i, 1);
    check("mid_occ", occ, 5);
    apply_reset("rst4");
    rd_ready = 1'b1;
    trig_pulse(4'hA, 9'h0AA, 32'hCAFEF00D, 1);   // expects evnum 0
    tick(2);
    rd_ready = 1'b0;

    // PPS at P, trigger at P+100
    pps = 1'b1;
    tick(1);
    pps = 1'b0;
    repeat (99) @(posedge fclk);
    #1;
`ifdef TRIG_INFO_TIMESTAMP_EN
    trig_pulse(4'h3, 9'h007, 32'h600D, 1, 1'b1, 32'd99);
`else
    trig_pulse(4'h3, 9'h007, 32'h600D, 1, 1'b1, 32'd0);
`endif
    rd_ready = 1'b1;
    tick(2);
    rd_ready = 1'b0;

    check("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
